// File: rtl/ad9361_spi_resp.sv
// AD9361 SPI slave emulator: oversampled SPI decode, 1024x8 register file, ID/lock/cal status overlays.
// Optional macro AD9361_SPI_RESP_CAL_EMU_EN enables the self-clearing cal-control emulation at 0x016.
module ad9361_spi_resp #(
    parameter logic [7:0] PRODUCT_ID  = 8'h0A,
    parameter int         CAL_DELAY   = 1000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wr_strobe,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       txn_active,
    output logic       frame_err
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] cs_sync_reg;
    logic [SYNC_N-1:0] sclk_sync_reg;
    logic [SYNC_N-1:0] mosi_sync_reg;
    logic              cs_d_reg;
    logic              sclk_d_reg;

    // CS samples reset low so that a reset released mid-frame (CS still low)
    // cannot be mistaken for a new CS fall.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_sync_reg   <= '0;
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_d_reg      <= 1'b0;
            sclk_d_reg    <= 1'b0;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[SYNC_N-2:0], spi_cs};
            sclk_sync_reg <= {sclk_sync_reg[SYNC_N-2:0], spi_sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_N-2:0], spi_mosi};
            cs_d_reg      <= cs_sync_reg[SYNC_N-1];
            sclk_d_reg    <= sclk_sync_reg[SYNC_N-1];
        end
    end

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    assign cs_s      = cs_sync_reg[SYNC_N-1];
    assign sclk_s    = sclk_sync_reg[SYNC_N-1];
    assign mosi_s    = mosi_sync_reg[SYNC_N-1];
    assign cs_fall   = cs_d_reg & ~cs_s;
    assign cs_rise   = ~cs_d_reg & cs_s;
    assign sclk_rise = ~sclk_d_reg & sclk_s;
    assign sclk_fall = sclk_d_reg & ~sclk_s;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [14:0] instr_reg, instr_next;
    logic [6:0]  rx_reg, rx_next;
    logic [7:0]  tx_reg, tx_next;
    logic [9:0]  addr_reg, addr_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [1:0]  load_reg, load_next;
    logic        miso_reg, miso_next;
    logic        oe_reg, oe_next;
    logic        wr_strobe_reg, wr_strobe_next;
    logic [9:0]  wr_addr_reg, wr_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        txn_reg, txn_next;
    logic        ferr_reg, ferr_next;

    logic        mem_we;
    logic [7:0]  mem_wd;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_byte;
    logic [7:0]  cal_value;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            instr_reg     <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            load_reg      <= '0;
            miso_reg      <= 1'b0;
            oe_reg        <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            txn_reg       <= 1'b0;
            ferr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            instr_reg     <= instr_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            load_reg      <= load_next;
            miso_reg      <= miso_next;
            oe_reg        <= oe_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            txn_reg       <= txn_next;
            ferr_reg      <= ferr_next;
        end
    end

    assign wr_byte = {rx_reg, mosi_s};
    // Soft-reset bits at 0x000 are never stored, so they read back cleared.
    assign mem_wd  = (addr_reg == 10'h000) ? (wr_byte & 8'h7E) : wr_byte;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        instr_next     = instr_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        load_next      = {load_reg[0], 1'b0};
        miso_next      = miso_reg;
        oe_next        = oe_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        txn_next       = txn_reg;
        ferr_next      = 1'b0;
        mem_we         = 1'b0;

        // Read byte lands in the shift register two cycles after the request.
        if (load_reg[1]) begin
            tx_next = rd_byte;
        end

        if (cs_rise) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            load_next    = '0;
            miso_next    = 1'b0;
            oe_next      = 1'b0;
            txn_next     = 1'b0;
            if ((bit_cnt_reg != 4'd0) &&
                ((state_reg == INSTR) || (state_reg == WDATA) || (state_reg == RDATA))) begin
                ferr_next = 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_next   = INSTR;
                        bit_cnt_next = '0;
                        txn_next     = 1'b1;
                    end
                end
                INSTR: begin
                    if (sclk_rise) begin
                        instr_next   = {instr_reg[13:0], mosi_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd15) begin
                            bit_cnt_next = '0;
                            addr_next    = {instr_reg[8:0], mosi_s};
                            cnt_next     = {1'b0, instr_reg[13:11]} + 4'd1;
                            if (instr_reg[14]) begin
                                state_next = WDATA;
                            end else begin
                                state_next   = RDATA;
                                load_next[0] = 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        rx_next      = {rx_reg[5:0], mosi_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next   = '0;
                            mem_we         = 1'b1;
                            wr_strobe_next = 1'b1;
                            wr_addr_next   = addr_reg;
                            wr_data_next   = wr_byte;
                            addr_next      = addr_reg - 10'd1;
                            cnt_next       = cnt_reg - 4'd1;
                            if (cnt_reg == 4'd1) begin
                                state_next = DONE;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        oe_next   = 1'b1;
                        miso_next = tx_reg[7];
                        tx_next   = {tx_reg[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = '0;
                            addr_next    = addr_reg - 10'd1;
                            cnt_next     = cnt_reg - 4'd1;
                            if (cnt_reg == 4'd1) begin
                                state_next = DONE;
                            end else begin
                                load_next[0] = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // Release the line on the trailing fall after the last bit.
                    if (sclk_fall) begin
                        oe_next = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register array: one write port, registered read of the current address
    // ------------------------------------------------------------------
    logic [7:0] mem [0:1023];
    logic [7:0] rd_data_reg;
    logic [9:0] rd_addr_reg;

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[addr_reg] <= mem_wd;
        end
        rd_data_reg <= mem[addr_reg];
        rd_addr_reg <= addr_reg;
    end

    always_comb begin
        rd_byte = rd_data_reg;
        case (rd_addr_reg)
            10'h037:          rd_byte = PRODUCT_ID;
            10'h05E:          rd_byte = 8'h80;
            10'h247, 10'h287: rd_byte = rd_data_reg | 8'h82;
            10'h016:          rd_byte = cal_value;
            default:          rd_byte = rd_data_reg;
        endcase
    end

`ifdef AD9361_SPI_RESP_CAL_EMU_EN
    localparam int CAL_W = (CAL_DELAY < 2) ? 1 : $clog2(CAL_DELAY + 1);

    logic [7:0]       cal_bits_reg;
    logic [CAL_W-1:0] cal_cnt_reg;
    logic             soft_rst;

    assign soft_rst = mem_we && (addr_reg == 10'h000) && (wr_byte[7] || wr_byte[0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cal_bits_reg <= '0;
            cal_cnt_reg  <= '0;
        end else if (soft_rst) begin
            cal_cnt_reg <= '0;
        end else if (mem_we && (addr_reg == 10'h016)) begin
            cal_bits_reg <= wr_byte;
            cal_cnt_reg  <= CAL_W'(CAL_DELAY);
        end else if (cal_cnt_reg != '0) begin
            cal_cnt_reg <= cal_cnt_reg - 1'b1;
        end
    end

    assign cal_value = (cal_cnt_reg != '0) ? cal_bits_reg : 8'h00;
`else
    assign cal_value = 8'h00;
`endif

    assign spi_miso    = miso_reg;
    assign spi_miso_oe = oe_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign txn_active  = txn_reg;
    assign frame_err   = ferr_reg;

endmodule

// File: doc/ad9361_spi_resp.md
Name: ad9361_spi_resp

Overview:
Synthesizable SPI responder that emulates the AD9361 SPI slave port, so the SPI master and its init sequencer can be exercised in simulation and in FPGA loopback without a transceiver fitted. It oversamples CS/SCLK/MOSI on sys_clk and decodes the 16-bit AD9361 instruction word. It serves reads and writes from a 1024x8 register array and returns a fixed product ID plus synthetic calibration/lock status.

Parameters:
PRODUCT_ID, 8'h0A, value returned for reads of 0x037 (read-only).
CAL_DELAY, 1000, sys_clk cycles before emulated cal-control bits self-clear.
SYNC_STAGES, 2, synchronizer depth on CS/SCLK/MOSI (min 2).

Ports:
sys_clk  in  1  system clock; must be at least 8x SCLK.
sys_rst_n  in  1  async active-low reset.
spi_cs  in  1  chip select, active low.
spi_sclk  in  1  SPI clock, CPOL=0; MOSI sampled on rising edge.
spi_mosi  in  1  master data, MSB first.
spi_miso  out  1  responder data; updated on SCLK falling edge.
spi_miso_oe  out  1  high while driving read data.
wr_strobe  out  1  one-cycle pulse per committed write byte.
wr_addr  out  10  address of committed write.
wr_data  out  8  data of committed write.
txn_active  out  1  high from CS fall to CS rise (synchronized).
frame_err  out  1  one-cycle pulse when CS rises mid-byte.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, txn_active=0, frame_err=0, FSM=IDLE, bit counter=0, array contents undefined except the status/ID map below.
- Inputs pass through SYNC_STAGES flops. Rise and fall edges of SCLK and fall and rise edges of CS are detected from the last two synchronized samples.
- Instruction word: bit15=1 write, 0 read; bits14:12=NB, giving NB+1 data bytes (1..8); bits11:10 ignored; bits9:0 = start address.
- FSM states:
  - IDLE -> INSTR on CS fall.
  - INSTR: shift 16 bits on SCLK rises. After bit 16, latch the fields and go to WDATA (write) or RDATA (read).
  - WDATA: shift 8 bits. On the 8th bit, commit the byte to the array and pulse wr_strobe one cycle later. Then decrement the address (wraps 0x000->0x3FF) and decrement the remaining-byte count. When the count reaches 0, go to DONE.
  - RDATA: at entry and after each byte, load the read byte into the shift register before the next SCLK fall; array read latency is 1 cycle, which fits within the 8x oversample. spi_miso presents the MSB on the first SCLK fall after the instruction and shifts on each fall. Address and count decrement as in WDATA.
  - DONE: ignore further SCLK until CS rise.
  - Any state -> IDLE on CS rise. spi_miso_oe drops on the same cycle. If the bit counter is not 0 and the state is not IDLE/DONE, pulse frame_err; the partial byte is discarded and not committed.
- Read map overrides (a write to a read-only address is stored but reads still return the override):
  - 0x037 -> PRODUCT_ID.
  - 0x05E -> 8'h80 (BBPLL locked).
  - 0x247, 0x287 -> array value | 8'h82 (CP cal done, VCO lock).
  - 0x016 -> cal-control register (see Optional Feature).
- Writes addressing 0x000 with data bit7 or bit0 set act as soft reset: array contents are kept, the cal counter is cleared, and the bits themselves self-clear.
- When sys_rst_n is asserted mid-transaction, the FSM aborts to IDLE immediately. The remainder of the frame is ignored until the next CS fall.

Optional Feature:
Macro AD9361_SPI_RESP_CAL_EMU_EN.
- Defined: a write to 0x016 loads its bits into a cal-control register and starts a CAL_DELAY countdown. Reads of 0x016 return the loaded bits until expiry, then 8'h00. This emulates the BBDC/RFDC/Rx-BB/Tx-BB/Tx-quad cal done polling. A new write restarts the countdown.
- Undefined: 0x016 always reads 8'h00, and no counter is instantiated.

Test Plan:
- Read 0x037, NB=0 (instr 16'h0037) -> MISO byte 8'h0A; spi_miso_oe high for exactly 8 SCLK periods; no wr_strobe.
- Write 3 bytes from 0x0FF, instr 16'hA0FF, data 11,22,33 -> wr_strobe x3 at addrs 0x0FF, 0x0FE, 0x0FD. A subsequent 3-byte read from 0x0FF returns 11,22,33.
- Write 0x000 data 8'h5A, then NB=1 read from 0x000 -> bytes 5A then the array value at 0x3FF (address wrap).
- CS released after 5 data bits of a write to 0x010 -> frame_err pulse; no wr_strobe; 0x010 unchanged on readback.
- With CAL_EMU_EN and CAL_DELAY=200: write 0x016=8'h01, read at ~50 cycles -> 8'h01, read after 200 cycles -> 8'h00. Without the macro, both reads -> 8'h00.
- sys_rst_n pulsed low mid-read -> spi_miso_oe=0 and FSM in IDLE within one cycle; the next full transaction completes normally.
